// File: rtl/niosballe_pio_edge_in_if.sv
// Avalon-MM slave bus for the Nios ball input PIO.
interface niosballe_pio_edge_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/niosballe_pio_edge_in.sv
// Input PIO for the Nios ball system: two-flop synchroniser, optional
// per-bit debounce, per-bit edge capture with write-1-to-clear and a
// maskable level interrupt. Registered reads with one cycle of latency.
module niosballe_pio_edge_in #(
  parameter int WIDTH           = 11,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  niosballe_pio_edge_in_if.slave   avs,
  input  logic [WIDTH-1:0]         in_port,
  output logic                     irq
);

  // Counter only has to reach DEBOUNCE_CYCLES-1; keep at least one bit.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'((DEBOUNCE_CYCLES > 1) ? (DEBOUNCE_CYCLES - 1) : 0);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_q_d;
  logic [CW-1:0]    r_cnt [WIDTH];
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_cap;

  logic             w_wr;
  logic [WIDTH-1:0] w_clear;
  logic [WIDTH-1:0] w_event;
  logic [31:0]      w_rd_data;

  assign w_wr = avs.chipselect && !avs.write_n;

  // Upper write-data bits have no storage behind them.
  if (WIDTH < 32) begin : g_wdata_pad
    logic w_unused_wdata;
    assign w_unused_wdata = ^avs.writedata[31:WIDTH];
  end

  // Two-stage synchroniser for the asynchronous board inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  // Per-bit debounce: a change is accepted only after holding for
  // DEBOUNCE_CYCLES consecutive cycles; any return to q restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] == r_q[i]) begin
          r_cnt[i] <= '0;
        end else if ((DEBOUNCE_CYCLES <= 1) || (r_cnt[i] == CNT_MAX)) begin
          r_q[i]   <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Delayed copy of the filtered value for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_q_d <= '0;
    else          r_q_d <= r_q;
  end

  // Edge event selection by EDGE_TYPE.
  always_comb begin
    w_event = '0;
    case (EDGE_TYPE)
      0:       w_event = r_q & ~r_q_d;
      1:       w_event = ~r_q & r_q_d;
      default: w_event = r_q ^ r_q_d;
    endcase
  end

  // Write-1-to-clear mask for the capture register.
  always_comb begin
    w_clear = '0;
    if (w_wr && (avs.address == 2'd3)) w_clear = avs.writedata[WIDTH-1:0];
  end

  // Mask register and edge capture; a new event beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_mask <= '0;
      r_edge_cap <= '0;
    end else begin
      if (w_wr && (avs.address == 2'd2)) r_irq_mask <= avs.writedata[WIDTH-1:0];
      r_edge_cap <= (r_edge_cap & ~w_clear) | w_event;
    end
  end

  // Read mux, zero-extended to the bus width.
  always_comb begin
    w_rd_data = '0;
    case (avs.address)
      2'd0:    w_rd_data[WIDTH-1:0] = r_q;
      2'd2:    w_rd_data[WIDTH-1:0] = r_irq_mask;
      2'd3:    w_rd_data[WIDTH-1:0] = r_edge_cap;
      default: w_rd_data = '0;
    endcase
  end

  // Registered read data, updated every cycle regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) avs.readdata <= '0;
    else          avs.readdata <= w_rd_data;
  end

  assign irq = |(r_edge_cap & r_irq_mask);

endmodule

// File: tb/tb_niosballe_pio_edge_in.sv
// Directed bench: instance A is rising-edge with no debounce, instance B
// is any-edge with a 4-cycle debounce filter.
module tb_niosballe_pio_edge_in;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] in_a;
  logic [10:0] in_b;
  logic        irq_a;
  logic        irq_b;
  logic [31:0] rd;
  int          checks   = 0;
  int          failures = 0;

  niosballe_pio_edge_in_if bus_a ();
  niosballe_pio_edge_in_if bus_b ();

  niosballe_pio_edge_in #(.WIDTH(11), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(0)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .avs(bus_a.slave), .in_port(in_a), .irq(irq_a)
  );

  niosballe_pio_edge_in #(.WIDTH(11), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(4)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .avs(bus_b.slave), .in_port(in_b), .irq(irq_b)
  );

  always #5 clk = ~clk;

  // Pass n rising edges, then settle on the following falling edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr_a(input logic [1:0] a, input logic [31:0] d);
    bus_a.address = a; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0; bus_a.writedata = d;
    @(posedge clk); @(negedge clk);
    bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1;
  endtask

  task automatic wr_b(input logic [1:0] a, input logic [31:0] d);
    bus_b.address = a; bus_b.chipselect = 1'b1; bus_b.write_n = 1'b0; bus_b.writedata = d;
    @(posedge clk); @(negedge clk);
    bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1;
  endtask

  task automatic rd_a(input logic [1:0] a, output logic [31:0] d);
    bus_a.address = a;
    tick(1);
    d = bus_a.readdata;
  endtask

  task automatic rd_b(input logic [1:0] a, output logic [31:0] d);
    bus_b.address = a;
    tick(1);
    d = bus_b.readdata;
  endtask

  initial begin
    reset_n = 1'b0;
    in_a = '0; in_b = '0;
    bus_a.address = 2'd0; bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.writedata = '0;
    bus_b.address = 2'd0; bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.writedata = '0;
    tick(3);
    check("reset_rd_a", bus_a.readdata, 32'h0);
    check("reset_irq_a", {31'h0, irq_a}, 32'h0);
    check("reset_rd_b", bus_b.readdata, 32'h0);
    check("reset_irq_b", {31'h0, irq_b}, 32'h0);
    reset_n = 1'b1;
    tick(2);

    // End-to-end latency: visible at E+3, not E+2.
    in_a = 11'h5A5;
    tick(3);
    check("latency_e2", bus_a.readdata, 32'h0);
    tick(1);
    check("latency_e3", bus_a.readdata, 32'h0000_05A5);
    rd_a(2'd3, rd);
    check("cap_5a5", rd, 32'h0000_05A5);
    check("irq_unmasked", {31'h0, irq_a}, 32'h0);
    wr_a(2'd3, 32'h0000_07FF);
    rd_a(2'd3, rd);
    check("cap_cleared", rd, 32'h0);
    in_a = 11'h000;
    tick(5);
    rd_a(2'd3, rd);
    check("falling_no_set", rd, 32'h0);
    rd_a(2'd0, rd);
    check("data_zero", rd, 32'h0);

    // Rising edge on bit 0 with mask bit 0.
    wr_a(2'd2, 32'h0000_0001);
    rd_a(2'd2, rd);
    check("mask_rb", rd, 32'h0000_0001);
    in_a = 11'h001;
    tick(3);
    check("irq_e2", {31'h0, irq_a}, 32'h0);
    tick(1);
    check("irq_e3", {31'h0, irq_a}, 32'h1);
    tick(6);
    in_a = 11'h000;
    tick(5);
    rd_a(2'd3, rd);
    check("cap_bit0", rd, 32'h0000_0001);
    wr_a(2'd3, 32'h0000_0001);
    check("irq_after_clear", {31'h0, irq_a}, 32'h0);

    // Unmasked edge, then unmasking raises irq right after the write.
    wr_a(2'd2, 32'h0);
    in_a = 11'h008;
    tick(5);
    rd_a(2'd3, rd);
    check("cap_bit3", rd, 32'h0000_0008);
    check("irq_masked_off", {31'h0, irq_a}, 32'h0);
    wr_a(2'd2, 32'h0000_0008);
    check("irq_on_unmask", {31'h0, irq_a}, 32'h1);
    rd_a(2'd2, rd);
    check("mask_rb8", rd, 32'h0000_0008);
    wr_a(2'd3, 32'h0000_0008);
    check("irq_clear8", {31'h0, irq_a}, 32'h0);

    // Writes to the read-only and reserved addresses are ignored.
    wr_a(2'd0, 32'hFFFF_FFFF);
    wr_a(2'd1, 32'hFFFF_FFFF);
    rd_a(2'd0, rd);
    check("ro_data", rd, 32'h0000_0008);
    rd_a(2'd1, rd);
    check("addr1_zero", rd, 32'h0);
    rd_a(2'd2, rd);
    check("mask_kept", rd, 32'h0000_0008);
    rd_a(2'd3, rd);
    check("cap_kept", rd, 32'h0);

    // Debounce: 3-cycle glitch is dropped.
    in_b = 11'h002;
    tick(3);
    in_b = 11'h000;
    tick(8);
    rd_b(2'd0, rd);
    check("glitch_data", rd, 32'h0);
    rd_b(2'd3, rd);
    check("glitch_cap", rd, 32'h0);

    // Debounce: 4-cycle hold accepted, q at E+5, readdata at E+6.
    bus_b.address = 2'd0;
    in_b = 11'h002;
    tick(6);
    check("deb_e5", bus_b.readdata, 32'h0);
    tick(1);
    check("deb_e6", bus_b.readdata, 32'h0000_0002);
    rd_b(2'd3, rd);
    check("deb_cap", rd, 32'h0000_0002);
    wr_b(2'd2, 32'h0000_0002);
    check("deb_irq", {31'h0, irq_b}, 32'h1);

    // Falling edge (any-edge mode) lands on the same edge as a clear.
    in_b = 11'h000;
    tick(6);
    check("pre_collide_irq", {31'h0, irq_b}, 32'h1);
    wr_b(2'd3, 32'h0000_0002);
    check("collide_irq", {31'h0, irq_b}, 32'h1);
    rd_b(2'd3, rd);
    check("collide_cap", rd, 32'h0000_0002);
    wr_b(2'd3, 32'h0000_0002);
    check("clear_b_irq", {31'h0, irq_b}, 32'h0);

    // Asynchronous reset between clock edges.
    wr_a(2'd2, 32'h0000_0010);
    in_a = 11'h018;
    bus_a.address = 2'd0;
    tick(4);
    check("pre_rst_rd", bus_a.readdata, 32'h0000_0018);
    check("pre_rst_irq", {31'h0, irq_a}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_rd", bus_a.readdata, 32'h0);
    check("async_rst_irq", {31'h0, irq_a}, 32'h0);
    in_a = 11'h000;
    tick(2);
    reset_n = 1'b1;
    rd_a(2'd2, rd);
    check("rst_mask", rd, 32'h0);
    rd_a(2'd3, rd);
    check("rst_cap", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
